// File: rtl/arch_defs_pkg.sv
// Shared architecture definitions for the UART blocks.
// Holds the receiver state encoding and bit-timing helper.
package arch_defs_pkg;

  typedef enum logic [1:0] {
    S_UART_RX_IDLE,
    S_UART_RX_VALIDATE_START,
    S_UART_RX_READ_DATA,
    S_UART_RX_STOP
  } uart_fsm_state_t;

  function automatic int clks_per_bit(
    input int clk_hz,
    input int baud
  );
    int q;
    q = clk_hz / baud;
    return (q < 4) ? 4 : q;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Register-side handshake bundle of the UART receiver.
// master = register layer, slave = receiver.
interface uart_receiver_if;
  logic       rx_read_ack;
  logic       rx_clear_errors;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic       rx_frame_error;
  logic       rx_overrun_error;
  logic       rx_busy;

  modport master (
    output rx_read_ack,
    output rx_clear_errors,
    input  rx_data,
    input  rx_data_ready,
    input  rx_frame_error,
    input  rx_overrun_error,
    input  rx_busy
  );

  modport slave (
    input  rx_read_ack,
    input  rx_clear_errors,
    output rx_data,
    output rx_data_ready,
    output rx_frame_error,
    output rx_overrun_error,
    output rx_busy
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Reset value is a parameter so idle-high lines reset to 1.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: start validation, LSB-first data,
// stop check, held byte with sticky frame/overrun flags.
module uart_receiver
  import arch_defs_pkg::*;
#(
  parameter int CLOCK_FREQ_HZ = 20_000_000,
  parameter int BAUD_RATE     = 115_200
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rx_serial_in,
  uart_receiver_if.slave rx
);
  localparam int CLKS_PER_BIT =
    clks_per_bit(CLOCK_FREQ_HZ, BAUD_RATE);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST =
    CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  uart_fsm_state_t  state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             brk;
  logic [1:0]       warm;
  logic             armed;
  logic             rx_sync;
  logic             stop_smp;
  logic             accept;
  logic             ferr_set;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx_serial_in),
    .q       (rx_sync)
  );

  assign stop_smp = (state == S_UART_RX_STOP) && !brk
                  && (cnt == BIT_LAST);
  assign accept   = stop_smp && rx_sync;
  assign ferr_set = stop_smp && !rx_sync;

  // Arming needs a real high after the synchronizer flushes
  // its reset value, so a mid-frame release is not a start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_UART_RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      brk     <= 1'b0;
      warm    <= '0;
      armed   <= 1'b0;
    end else begin
      warm <= {warm[0], 1'b1};
      unique case (state)
        S_UART_RX_IDLE: begin
          cnt <= '0;
          if (warm[1] && rx_sync)
            armed <= 1'b1;
          if (armed && !rx_sync)
            state <= S_UART_RX_VALIDATE_START;
        end
        S_UART_RX_VALIDATE_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? S_UART_RX_IDLE
                               : S_UART_RX_READ_DATA;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_UART_RX_READ_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7)
              state <= S_UART_RX_STOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_UART_RX_STOP: begin
          if (brk) begin
            if (rx_sync) begin
              brk   <= 1'b0;
              state <= S_UART_RX_IDLE;
            end
          end else if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_sync) state <= S_UART_RX_IDLE;
            else         brk   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= S_UART_RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx.rx_data          <= '0;
      rx.rx_data_ready    <= 1'b0;
      rx.rx_frame_error   <= 1'b0;
      rx.rx_overrun_error <= 1'b0;
    end else begin
      if (accept) begin
        rx.rx_data       <= shift;
        rx.rx_data_ready <= 1'b1;
      end else if (rx.rx_read_ack) begin
        rx.rx_data_ready <= 1'b0;
      end
      if (accept && rx.rx_data_ready && !rx.rx_read_ack)
        rx.rx_overrun_error <= 1'b1;
      else if (rx.rx_clear_errors)
        rx.rx_overrun_error <= 1'b0;
      if (ferr_set)
        rx.rx_frame_error <= 1'b1;
      else if (rx.rx_clear_errors)
        rx.rx_frame_error <= 1'b0;
    end
  end

  assign rx.rx_busy = (state != S_UART_RX_IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at 16 clocks/bit.
// Expected bytes go through a scoreboard queue.
module tb_uart_receiver;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic line = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] exp_q[$];

  uart_receiver_if rif ();

  uart_receiver #(
    .CLOCK_FREQ_HZ (1_600_000),
    .BAUD_RATE     (100_000)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_serial_in (line),
    .rx           (rif)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(
    input  logic [7:0] b,
    input  logic       stop,
    input  logic       ack_at_accept,
    output int         rdy_k
  );
    logic prev;
    rdy_k = 0;
    line = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      repeat (16) @(negedge clk);
    end
    line = stop;
    if (stop) exp_q.push_back(b);
    prev = rif.rx_data_ready;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (rdy_k == 0 && rif.rx_data_ready && !prev)
        rdy_k = k;
      prev = rif.rx_data_ready;
      if (ack_at_accept)
        rif.rx_read_ack = (k == 10);
    end
    rif.rx_read_ack = 1'b0;
  endtask

  task automatic pulse_ack();
    rif.rx_read_ack = 1'b1;
    @(negedge clk);
    rif.rx_read_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] o;
    repeat (3) @(negedge clk);
    o = {rif.rx_data, rif.rx_data_ready,
         rif.rx_frame_error, rif.rx_overrun_error,
         rif.rx_busy};
    checks++;
    if (o !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=000", o);
    end
    reset_n = 1'b1;
    idle(10);
  endtask

  task automatic test_valid();
    int k;
    logic [7:0] e;
    send_frame(8'hA5, 1'b1, 1'b0, k);
    idle(4);
    e = 8'hxx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    checks++;
    if (rif.rx_data !== e) begin
      failures++;
      $display("FAIL valid_data got=%h exp=%h", rif.rx_data, e);
    end
    checks++;
    if (rif.rx_data_ready !== 1'b1) begin
      failures++;
      $display("FAIL valid_ready got=%b exp=1", rif.rx_data_ready);
    end
    checks++;
    if (k < 8 || k > 11) begin
      failures++;
      $display("FAIL valid_latency got=%0d exp=8..11", k);
    end
    checks++;
    if ({rif.rx_frame_error, rif.rx_overrun_error} !== 2'b00) begin
      failures++;
      $display("FAIL valid_errs got=%b%b exp=00",
               rif.rx_frame_error, rif.rx_overrun_error);
    end
    pulse_ack();
    checks++;
    if ({rif.rx_data_ready, rif.rx_data} !== {1'b0, 8'hA5}) begin
      failures++;
      $display("FAIL ack_clear got=%b/%h exp=0/a5",
               rif.rx_data_ready, rif.rx_data);
    end
  endtask

  task automatic test_glitch();
    logic seen;
    seen = 1'b0;
    line = 1'b0;
    repeat (4) @(negedge clk);
    line = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rif.rx_busy) seen = 1'b1;
    end
    checks++;
    if ({seen, rif.rx_busy, rif.rx_data_ready} !== 3'b100) begin
      failures++;
      $display("FAIL glitch got=seen%b busy%b rdy%b exp=100",
               seen, rif.rx_busy, rif.rx_data_ready);
    end
  endtask

  task automatic test_frame_error();
    int k;
    logic [7:0] e;
    send_frame(8'h3C, 1'b0, 1'b0, k);
    repeat (40) @(negedge clk);
    checks++;
    if ({rif.rx_frame_error, rif.rx_data_ready, rif.rx_busy}
        !== 3'b101) begin
      failures++;
      $display("FAIL frame_err got=ferr%b rdy%b busy%b exp=101",
               rif.rx_frame_error, rif.rx_data_ready, rif.rx_busy);
    end
    idle(20);
    checks++;
    if (rif.rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL break_exit got=%b exp=0", rif.rx_busy);
    end
    send_frame(8'h55, 1'b1, 1'b0, k);
    idle(4);
    e = 8'hxx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    checks++;
    if ({rif.rx_data_ready, rif.rx_data} !== {1'b1, e}) begin
      failures++;
      $display("FAIL after_break got=%b/%h exp=1/%h",
               rif.rx_data_ready, rif.rx_data, e);
    end
    pulse_ack();
  endtask

  task automatic test_overrun();
    int k;
    logic [7:0] e;
    send_frame(8'h11, 1'b1, 1'b0, k);
    idle(4);
    e = 8'hxx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    checks++;
    if (rif.rx_data !== e) begin
      failures++;
      $display("FAIL ovr_first got=%h exp=%h", rif.rx_data, e);
    end
    send_frame(8'h22, 1'b1, 1'b0, k);
    idle(4);
    e = 8'hxx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    checks++;
    if ({rif.rx_data, rif.rx_overrun_error, rif.rx_data_ready}
        !== {e, 2'b11}) begin
      failures++;
      $display("FAIL overrun got=%h ovr%b rdy%b exp=%h ovr1 rdy1",
               rif.rx_data, rif.rx_overrun_error,
               rif.rx_data_ready, e);
    end
  endtask

  task automatic test_clear_errors();
    checks++;
    if ({rif.rx_frame_error, rif.rx_overrun_error} !== 2'b11) begin
      failures++;
      $display("FAIL clr_pre got=%b%b exp=11",
               rif.rx_frame_error, rif.rx_overrun_error);
    end
    rif.rx_clear_errors = 1'b1;
    @(negedge clk);
    rif.rx_clear_errors = 1'b0;
    checks++;
    if ({rif.rx_frame_error, rif.rx_overrun_error} !== 2'b00) begin
      failures++;
      $display("FAIL clr_post got=%b%b exp=00",
               rif.rx_frame_error, rif.rx_overrun_error);
    end
  endtask

  task automatic test_ack_at_accept();
    int k;
    logic [7:0] e;
    pulse_ack();
    send_frame(8'h11, 1'b1, 1'b0, k);
    idle(4);
    e = 8'hxx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    checks++;
    if ({rif.rx_data, rif.rx_overrun_error} !== {e, 1'b0}) begin
      failures++;
      $display("FAIL acc_first got=%h ovr%b exp=%h ovr0",
               rif.rx_data, rif.rx_overrun_error, e);
    end
    send_frame(8'h22, 1'b1, 1'b1, k);
    idle(4);
    e = 8'hxx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    checks++;
    if ({rif.rx_data, rif.rx_data_ready, rif.rx_overrun_error}
        !== {e, 2'b10}) begin
      failures++;
      $display("FAIL ack_accept got=%h rdy%b ovr%b exp=%h rdy1 ovr0",
               rif.rx_data, rif.rx_data_ready,
               rif.rx_overrun_error, e);
    end
  endtask

  task automatic test_reset_mid_frame();
    int k;
    logic [7:0] e;
    logic [11:0] o;
    line = 1'b0;
    repeat (16 * 4 + 8) @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    o = {rif.rx_data, rif.rx_data_ready,
         rif.rx_frame_error, rif.rx_overrun_error,
         rif.rx_busy};
    checks++;
    if (o !== 12'h000) begin
      failures++;
      $display("FAIL midreset_outputs got=%h exp=000", o);
    end
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    line = 1'b1;
    repeat (16 * 5) @(negedge clk);
    idle(10);
    checks++;
    if ({rif.rx_data_ready, rif.rx_busy, rif.rx_frame_error}
        !== 3'b000) begin
      failures++;
      $display("FAIL no_resync got=rdy%b busy%b ferr%b exp=000",
               rif.rx_data_ready, rif.rx_busy, rif.rx_frame_error);
    end
    send_frame(8'h0F, 1'b1, 1'b0, k);
    idle(4);
    e = 8'hxx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    checks++;
    if ({rif.rx_data, rif.rx_data_ready, rif.rx_frame_error}
        !== {e, 2'b10}) begin
      failures++;
      $display("FAIL post_reset got=%h rdy%b ferr%b exp=%h rdy1 ferr0",
               rif.rx_data, rif.rx_data_ready,
               rif.rx_frame_error, e);
    end
  endtask

  initial begin
    rif.rx_read_ack = 1'b0;
    rif.rx_clear_errors = 1'b0;
    test_reset();
    test_valid();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_clear_errors();
    test_ack_at_accept();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter CLOCK_FREQ_HZ, default 20_000_000, meaning system clock frequency.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115_200, meaning serial bit rate; CLKS_PER_BIT = CLOCK_FREQ_HZ / BAUD_RATE, integer division, minimum 4.
REQ-003 The block SHALL have port clk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-005 The block SHALL have port rx_serial_in, input, 1, meaning asynchronous serial line, idle high.
REQ-006 The block SHALL have port rx_read_ack, input, 1, meaning a one-cycle pulse from the register layer that consumes the held byte.
REQ-007 The block SHALL have port rx_clear_errors, input, 1, meaning a one-cycle pulse that clears the sticky error flags.
REQ-008 The block SHALL have port rx_data, output, 8, meaning the last accepted byte.
REQ-009 The block SHALL have port rx_data_ready, output, 1, meaning rx_data holds an unconsumed byte.
REQ-010 The block SHALL have ports rx_frame_error and rx_overrun_error, output, 1 each, meaning sticky error flags.
REQ-011 The block SHALL have port rx_busy, output, 1, meaning the FSM is not in S_UART_RX_IDLE.

Function
REQ-012 rx_serial_in SHALL pass through a 2-flop synchronizer reset to 1; all FSM decisions SHALL use the synchronized value (rx_sync).
REQ-013 The FSM SHALL use states S_UART_RX_IDLE, S_UART_RX_VALIDATE_START, S_UART_RX_READ_DATA and S_UART_RX_STOP.
REQ-014 In IDLE, rx_sync = 0 SHALL cause a move to VALIDATE_START, with the clock counter cleared.
REQ-015 VALIDATE_START SHALL count CLKS_PER_BIT/2 cycles and then sample. If rx_sync = 0, the FSM SHALL go to READ_DATA with counter and bit index cleared. If rx_sync = 1, it SHALL treat the event as a glitch and return to IDLE with no flag change.
REQ-016 READ_DATA SHALL sample rx_sync every CLKS_PER_BIT cycles, shifting bits in LSB first. After bit index 7 is sampled it SHALL go to STOP.
REQ-017 STOP SHALL wait CLKS_PER_BIT cycles and then sample.
- Sample = 1: the shifted byte SHALL be loaded into rx_data, rx_data_ready SHALL be set on the next edge, and the FSM SHALL return to IDLE.
- Sample = 0: the byte SHALL be discarded, rx_frame_error SHALL be set, and the FSM SHALL remain in STOP until rx_sync = 1, then go to IDLE. This prevents retriggering on a break condition.
REQ-018 If a byte is accepted while rx_data_ready = 1 and rx_read_ack is not asserted in that cycle, rx_data SHALL be overwritten and rx_overrun_error SHALL be set.
REQ-019 If rx_read_ack and a byte accept occur in the same cycle, rx_data_ready SHALL stay 1 with the new byte and no overrun SHALL be flagged.
REQ-020 rx_read_ack with no accept SHALL clear rx_data_ready on the next edge; rx_data SHALL hold its value.
REQ-021 rx_clear_errors SHALL clear both error flags. An error set in the same cycle SHALL take priority, leaving the flag at 1.
REQ-022 The clock counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL never wrap within a bit period. The bit index SHALL be 3 bits.

Reset
REQ-023 While reset_n = 0, the block SHALL drive: state = IDLE, counters = 0, shift register = 0x00, rx_data = 0x00, rx_data_ready = 0, both errors = 0, rx_busy = 0, synchronizer flops = 1.
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no flag set. After release, the block SHALL wait for the next falling edge and SHALL NOT resynchronize mid-frame.

Structure
REQ-025 uart_fsm_state_t SHALL remain in arch_defs_pkg and be used for the RX state register. UART_RX_OVERSAMPLE-free timing constants SHALL be local parameters.
REQ-026 The synchronizer SHALL be a separate reusable sub-module, sync_2ff, with reset value 1 as a parameter.

Verification
Bench parameters: CLOCK_FREQ_HZ = 1_600_000 and BAUD_RATE = 100_000, giving CLKS_PER_BIT = 16.
REQ-027 Frame 0xA5 with valid stop -> rx_data = 0xA5 and rx_data_ready = 1 within 2 cycles of the stop mid-sample; no error flags set.
REQ-028 A 4-cycle low glitch on an idle line -> rx_busy pulses, FSM returns to IDLE, and rx_data_ready stays 0.
REQ-029 Frame 0x3C with stop bit = 0 -> rx_frame_error = 1 and rx_data_ready = 0. After the line returns high, frame 0x55 -> rx_data = 0x55.
REQ-030 Frames 0x11 then 0x22 without ack -> rx_data = 0x22 and rx_overrun_error = 1. Repeating with rx_read_ack pulsed on the exact accept cycle of 0x22 -> rx_data_ready = 1 and overrun = 0.
REQ-031 reset_n pulsed low during bit 3 of frame 0xF0 -> all outputs return to reset values. The next frame 0x0F SHALL then be received correctly.
REQ-032 rx_clear_errors pulsed with both flags set -> both flags read 0 on the next cycle.
